// File: rtl/bypass_pkg.sv
// Shared types for the bypass/forwarding controller: select encoding, FSM states
// and the per-stage destination tag record.
package bypass_pkg;

  localparam int TAG_MAX_W = 8;
  localparam int CNT_W     = 4;

  localparam logic [CNT_W-1:0]     CNT_ZERO = 4'd0;
  localparam logic [CNT_W-1:0]     CNT_ONE  = 4'd1;
  localparam logic [TAG_MAX_W-1:0] TAG_X0   = 8'd0;

  typedef enum logic [1:0] {
    SEL_FILE   = 2'b00,
    SEL_EX     = 2'b01,
    SEL_MM_PRO = 2'b10,
    SEL_MM_MEM = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic                 v;
    logic [TAG_MAX_W-1:0] rd;
    logic                 ld;
  } stage_tag_t;

  localparam stage_tag_t SLOT_EMPTY = '{v: 1'b0, rd: 8'd0, ld: 1'b0};

  // x0 never matches, even if a stale slot were to carry it
  function automatic logic slot_hit(input stage_tag_t slot, input logic [TAG_MAX_W-1:0] tag);
    return slot.v && (tag != TAG_X0) && (slot.rd == tag);
  endfunction

endpackage

// File: rtl/bypass_match.sv
// Per-source comparator: picks the youngest producing stage and flags a
// load-use hazard when the youngest producer is a load still in EX.
module bypass_match
  import bypass_pkg::*;
(
  input  logic [TAG_MAX_W-1:0] src,
  input  logic                 used,
  input  stage_tag_t           ex,
  input  stage_tag_t           mm,
  output fwd_sel_e             sel,
  output logic                 hazard
);

  logic ex_hit_s;
  logic mm_hit_s;

  assign ex_hit_s = used && slot_hit(ex, src);
  assign mm_hit_s = used && slot_hit(mm, src);
  assign hazard   = ex_hit_s && ex.ld;

  // youngest-first priority; the value during a hazard is never consumed
  always_comb begin
    sel = SEL_FILE;
    if (ex_hit_s && !ex.ld) begin
      sel = SEL_EX;
    end else if (mm_hit_s && !mm.ld) begin
      sel = SEL_MM_PRO;
    end else if (mm_hit_s && mm.ld) begin
      sel = SEL_MM_MEM;
    end else begin
      sel = SEL_FILE;
    end
  end

endmodule

// File: rtl/bypass_ctrl.sv
// Operand bypass controller with load-use and multi-cycle (long op) interlock.
// Optional stall counter output enabled by defining BYPASS_CTRL_STATS_EN.
module bypass_ctrl
  import bypass_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int REG_NUM    = 32,
  parameter  int LONG_LAT   = 4,
  localparam int TAG_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [TAG_W-1:0] id_rs1,
  input  logic [TAG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [TAG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             id_is_long,
  input  logic             flush,
  output logic [1:0]       fwd_sel_rs1,
  output logic [1:0]       fwd_sel_rs2,
  output logic             busy
`ifdef BYPASS_CTRL_STATS_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  if (LONG_LAT < 2 || LONG_LAT > 16) begin : g_bad_long_lat
    $error("bypass_ctrl: LONG_LAT must be within 2..16");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("bypass_ctrl: DATA_WIDTH must be positive");
  end
  if (TAG_W > TAG_MAX_W) begin : g_bad_reg_num
    $error("bypass_ctrl: REG_NUM exceeds the tag width held in stage slots");
  end

  state_e               state_r, state_n;
  logic [CNT_W-1:0]     cnt_r, cnt_n;
  stage_tag_t           ex_r, ex_n;
  stage_tag_t           mm_r, mm_n;
  stage_tag_t           new_slot_s;
  fwd_sel_e             sel1_s, sel2_s;
  logic                 haz1_s, haz2_s;
  logic                 id_ready_s;
  logic                 issue_s;
  logic                 is_long_s;
  logic [TAG_MAX_W-1:0] rs1_ext_s, rs2_ext_s, rd_ext_s;

  assign rs1_ext_s = TAG_MAX_W'(id_rs1);
  assign rs2_ext_s = TAG_MAX_W'(id_rs2);
  assign rd_ext_s  = TAG_MAX_W'(id_rd);

  bypass_match u_match_rs1 (
    .src    (rs1_ext_s),
    .used   (id_rs1_used),
    .ex     (ex_r),
    .mm     (mm_r),
    .sel    (sel1_s),
    .hazard (haz1_s)
  );

  bypass_match u_match_rs2 (
    .src    (rs2_ext_s),
    .used   (id_rs2_used),
    .ex     (ex_r),
    .mm     (mm_r),
    .sel    (sel2_s),
    .hazard (haz2_s)
  );

  assign id_ready_s = !flush && (state_r == RUN) && !(haz1_s || haz2_s);
  assign issue_s    = id_valid && id_ready_s;
  // a load that is also flagged long is treated purely as a load
  assign is_long_s  = id_is_long && !id_is_load;

  assign new_slot_s.v  = id_rd_we && (rd_ext_s != TAG_X0);
  assign new_slot_s.rd = rd_ext_s;
  assign new_slot_s.ld = id_is_load;

  assign id_ready    = id_ready_s;
  assign fwd_sel_rs1 = sel1_s;
  assign fwd_sel_rs2 = sel2_s;
  assign busy        = (state_r == MC_BUSY);

  // pipeline slot advance and long-op occupancy FSM, flush dominant
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    ex_n    = ex_r;
    mm_n    = mm_r;
    if (flush) begin
      state_n = RUN;
      cnt_n   = CNT_ZERO;
      ex_n    = SLOT_EMPTY;
      mm_n    = SLOT_EMPTY;
    end else begin
      case (state_r)
        RUN: begin
          mm_n = ex_r;
          ex_n = issue_s ? new_slot_s : SLOT_EMPTY;
          if (issue_s && is_long_s) begin
            state_n = MC_BUSY;
            cnt_n   = CNT_W'(LONG_LAT - 1);
          end else begin
            state_n = RUN;
          end
        end
        MC_BUSY: begin
          ex_n = ex_r;
          mm_n = SLOT_EMPTY;
          if (cnt_r <= CNT_ONE) begin
            state_n = RUN;
            cnt_n   = CNT_ZERO;
          end else begin
            state_n = MC_BUSY;
            cnt_n   = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_n = RUN;
          cnt_n   = CNT_ZERO;
          ex_n    = SLOT_EMPTY;
          mm_n    = SLOT_EMPTY;
        end
      endcase
    end
  end

  // state, counter and slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      cnt_r   <= CNT_ZERO;
      ex_r    <= SLOT_EMPTY;
      mm_r    <= SLOT_EMPTY;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ex_r    <= ex_n;
      mm_r    <= mm_n;
    end
  end

`ifdef BYPASS_CTRL_STATS_EN
  logic [31:0] stall_cycles_r;

  // saturating count of cycles with a pending but refused op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_r <= 32'd0;
    end else if (id_valid && !id_ready_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_r;
`endif

endmodule
